// File: rtl/intra4x4_mode_decision_pkg.sv
// ============================================================================
// Module : intra4x4_pkg
// Shared constants, mode lookup and state type for intra 4x4 mode decision.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package intra4x4_pkg;

  localparam logic [3:0] MODE_V   = 4'd0;
  localparam logic [3:0] MODE_H   = 4'd1;
  localparam logic [3:0] MODE_DC  = 4'd2;
  localparam logic [3:0] MODE_DDL = 4'd3;
  localparam logic [3:0] MODE_DDR = 4'd4;
  localparam logic [3:0] MODE_VR  = 4'd5;
  localparam logic [3:0] MODE_HD  = 4'd6;
  localparam logic [3:0] MODE_VL  = 4'd7;
  localparam logic [3:0] MODE_HU  = 4'd8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  // Evaluation slots skip DC, so slots 2..7 map to modes 3..8.
  function automatic logic [3:0] slot_to_mode(input logic [2:0] slot);
    logic [3:0] mode;
    case (slot)
      3'd0:    mode = MODE_V;
      3'd1:    mode = MODE_H;
      3'd2:    mode = MODE_DDL;
      3'd3:    mode = MODE_DDR;
      3'd4:    mode = MODE_VR;
      3'd5:    mode = MODE_HD;
      3'd6:    mode = MODE_VL;
      default: mode = MODE_HU;
    endcase
    return mode;
  endfunction

  function automatic int sad_width(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/intra4x4_mode_decision_if.sv
// ============================================================================
// Module : intra4x4_mode_decision_if
// Request, candidate-array and result bundle for the mode decision block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface intra4x4_mode_decision_if #(
  parameter int PIX_W = 8
);

  logic                       start;
  logic [7:0]                 mode_en;
  logic [15:0][PIX_W-1:0]     orig;
  logic [15:0][PIX_W-1:0]     vpred;
  logic [15:0][PIX_W-1:0]     hpred;
  logic [15:0][PIX_W-1:0]     ddlpred;
  logic [15:0][PIX_W-1:0]     ddrpred;
  logic [15:0][PIX_W-1:0]     vrpred;
  logic [15:0][PIX_W-1:0]     hdpred;
  logic [15:0][PIX_W-1:0]     vlpred;
  logic [15:0][PIX_W-1:0]     hupred;
  logic                       busy;
  logic                       done;
  logic [3:0]                 best_mode;
  logic [PIX_W+3:0]           best_sad;
  logic [15:0][PIX_W-1:0]     best_pred;

  modport master (
    output start, mode_en, orig,
    output vpred, hpred, ddlpred, ddrpred, vrpred, hdpred, vlpred, hupred,
    input  busy, done, best_mode, best_sad, best_pred
  );

  modport slave (
    input  start, mode_en, orig,
    input  vpred, hpred, ddlpred, ddrpred, vrpred, hdpred, vlpred, hupred,
    output busy, done, best_mode, best_sad, best_pred
  );

endinterface

`default_nettype wire

// File: rtl/intra4x4_mode_decision_sad_row4.sv
// ============================================================================
// Module : sad_row4
// Combinational sum of absolute differences over four pixel pairs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sad_row4 #(
  parameter int PIX_W = 8
) (
  input  logic [3:0][PIX_W-1:0] orig_px,
  input  logic [3:0][PIX_W-1:0] pred_px,
  output logic [PIX_W+1:0]      sad
);

  logic [3:0][PIX_W-1:0] diff;

  generate
    for (genvar c = 0; c < 4; c++) begin : g_absdiff
      assign diff[c] = (orig_px[c] >= pred_px[c]) ? (orig_px[c] - pred_px[c])
                                                  : (pred_px[c] - orig_px[c]);
    end
  endgenerate

  assign sad = {2'b00, diff[0]} + {2'b00, diff[1]}
             + {2'b00, diff[2]} + {2'b00, diff[3]};

endmodule

`default_nettype wire

// File: rtl/intra4x4_mode_decision.sv
// ============================================================================
// Module : intra4x4_mode_decision
// Sequential SAD evaluation of eight 4x4 intra candidates, one row per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module intra4x4_mode_decision
  import intra4x4_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  intra4x4_mode_decision_if.slave   bus
);

  localparam int SAD_W = sad_width(PIX_W);

  typedef logic [15:0][PIX_W-1:0] blk_t;

  state_t               state_q, state_d;
  logic [4:0]           step_q, step_d;
  logic [SAD_W-1:0]     acc_q, acc_d;
  logic [SAD_W-1:0]     run_sad_q, run_sad_d;
  logic [3:0]           run_mode_q, run_mode_d;
  blk_t                 run_pred_q, run_pred_d;
  logic [SAD_W-1:0]     best_sad_q, best_sad_d;
  logic [3:0]           best_mode_q, best_mode_d;
  blk_t                 best_pred_q, best_pred_d;
  logic                 done_q, done_d;

  logic [2:0]           slot;
  logic [1:0]           row;
  blk_t                 cand;
  logic [3:0][PIX_W-1:0] orig_row;
  logic [3:0][PIX_W-1:0] pred_row;
  logic [PIX_W+1:0]     row_sad;
  logic [SAD_W-1:0]     mode_sad;

  assign slot = step_q[4:2];
  assign row  = step_q[1:0];

  always_comb begin
    cand = bus.vpred;
    case (slot)
      3'd0:    cand = bus.vpred;
      3'd1:    cand = bus.hpred;
      3'd2:    cand = bus.ddlpred;
      3'd3:    cand = bus.ddrpred;
      3'd4:    cand = bus.vrpred;
      3'd5:    cand = bus.hdpred;
      3'd6:    cand = bus.vlpred;
      default: cand = bus.hupred;
    endcase
  end

  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign orig_row[c] = bus.orig[{row, 2'(c)}];
      assign pred_row[c] = cand[{row, 2'(c)}];
    end
  endgenerate

  sad_row4 #(
    .PIX_W (PIX_W)
  ) u_sad_row4 (
    .orig_px (orig_row),
    .pred_px (pred_row),
    .sad     (row_sad)
  );

  assign mode_sad = acc_q + SAD_W'(row_sad);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    run_sad_d   = run_sad_q;
    run_mode_d  = run_mode_q;
    run_pred_d  = run_pred_q;
    best_sad_d  = best_sad_q;
    best_mode_d = best_mode_q;
    best_pred_d = best_pred_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = EVAL;
          step_d     = '0;
          acc_d      = '0;
          run_sad_d  = '1;
          run_mode_d = MODE_DC;
        end
      end
      EVAL: begin
        step_d = step_q + 5'd1;
        acc_d  = mode_sad;
        if (row == 2'd3) begin
          acc_d = '0;
          // Strict compare keeps the earlier slot on ties.
          if (bus.mode_en[slot] && (mode_sad < run_sad_q)) begin
            run_sad_d  = mode_sad;
            run_mode_d = slot_to_mode(slot);
            run_pred_d = cand;
          end
          if (step_q == 5'd31) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            best_sad_d  = run_sad_d;
            best_mode_d = run_mode_d;
            if (bus.mode_en != 8'd0) begin
              best_pred_d = run_pred_d;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      acc_q       <= '0;
      run_sad_q   <= '1;
      run_mode_q  <= MODE_DC;
      run_pred_q  <= '0;
      best_sad_q  <= '1;
      best_mode_q <= MODE_DC;
      best_pred_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      run_sad_q   <= run_sad_d;
      run_mode_q  <= run_mode_d;
      run_pred_q  <= run_pred_d;
      best_sad_q  <= best_sad_d;
      best_mode_q <= best_mode_d;
      best_pred_q <= best_pred_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q == EVAL);
  assign bus.done      = done_q;
  assign bus.best_mode = best_mode_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.best_pred = best_pred_q;

endmodule

`default_nettype wire
